// File: rtl/byte_receiver_if.sv
// Bundles the serial input and word-handshake signals of the JTAG byte
// receiver. The TAP side (master) drives enable, tdi and out_ready; the
// receiver (slave) presents the assembled word and its status flags.

interface byte_receiver_if #(
    parameter int WIDTH = 32
);
    localparam int COUNT_W = $clog2(WIDTH + 1);

    logic               enable;
    logic               tdi;
    logic [WIDTH-1:0]   out;
    logic               out_valid;
    logic               out_ready;
    logic               done;
    logic [COUNT_W-1:0] bit_count;
    logic               overflow;

    modport master (
        output enable,
        output tdi,
        output out_ready,
        input  out,
        input  out_valid,
        input  done,
        input  bit_count,
        input  overflow
    );

    modport slave (
        input  enable,
        input  tdi,
        input  out_ready,
        output out,
        output out_valid,
        output done,
        output bit_count,
        output overflow
    );
endinterface

// File: rtl/byte_receiver.sv
// JTAG data-path deserializer. Samples TDI MSB first on every TCK rising
// edge while enable is high and assembles WIDTH-bit words back to back.
// Each completed word lands in a valid/ready holding register; a word that
// completes while the holding register is still full is dropped and the
// sticky overflow flag is raised.

module byte_receiver #(
    parameter int WIDTH = 32
) (
    input  logic            clk_tck,
    input  logic            reset,
    byte_receiver_if.slave  bus
);
    localparam int COUNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]         state;
    // Only the low WIDTH-1 bits are ever needed: the top bit of a word is
    // shifted out at the very edge that completes it.
    logic [WIDTH-2:0]   sr;
    logic [COUNT_W-1:0] bit_count_q;
    logic [WIDTH-1:0]   out_q;
    logic               out_valid_q;
    logic               done_q;
    logic               overflow_q;

    logic [WIDTH-1:0]   next_word;
    logic               word_complete;
    logic               accept;

    assign next_word     = {sr, bus.tdi};
    assign word_complete = bus.enable && (bit_count_q == COUNT_W'(WIDTH - 1));
    assign accept        = out_valid_q && bus.out_ready;

    // Shift path: capture one bit per edge while enabled, wrap the counter
    // at a word boundary, and discard any partial word when enable drops.
    always_ff @(posedge clk_tck or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sr          <= '0;
            bit_count_q <= '0;
        end else if (bus.enable) begin
            state <= SHIFT;
            sr    <= next_word[WIDTH-2:0];
            if (word_complete) begin
                bit_count_q <= '0;
            end else begin
                bit_count_q <= bit_count_q + COUNT_W'(1);
            end
        end else if (state == SHIFT) begin
            state       <= IDLE;
            sr          <= '0;
            bit_count_q <= '0;
        end
    end

    // Holding register: load a finished word when the slot is free or being
    // emptied on the same edge, otherwise drop it and flag overflow.
    always_ff @(posedge clk_tck or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (word_complete) begin
            if (!out_valid_q || bus.out_ready) begin
                out_q       <= next_word;
                out_valid_q <= 1'b1;
            end else begin
                overflow_q <= 1'b1;
            end
        end else if (accept) begin
            out_valid_q <= 1'b0;
        end
    end

    // One-cycle completion pulse, raised whether the word was kept or dropped.
    always_ff @(posedge clk_tck or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= word_complete;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;
    assign bus.bit_count = bit_count_q;
    assign bus.overflow  = overflow_q;

endmodule
